// File: rtl/audio_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared audio types: sample type, PCM streamer states and
//            word-select tags used by the streamer and the I2S controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_SEND_L = 3'd3,
    S_SEND_R = 3'd4,
    S_DONE   = 3'd5,
    S_STOP   = 3'd6
  } streamer_state_t;

  // Channel tag on the word stream, matched by the I2S controller's WS line.
  localparam logic WS_LEFT  = 1'b1;
  localparam logic WS_RIGHT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/pcm_attenuator.sv
// ============================================================================
// Module   : pcm_attenuator
// Purpose  : Combinational signed attenuator, output = sample >>> shift.
//            Large shifts sign-fill to 0 or -1; no saturation is required.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_attenuator #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic [W-1:0]  i_sample,
  input  logic [SW-1:0] i_shift,
  output logic [W-1:0]  o_sample
);

  logic signed [W-1:0] w_sample;

  assign w_sample = $signed(i_sample);
  assign o_sample = w_sample >>> i_shift;

endmodule

`default_nettype wire

// File: rtl/pcm_rom_streamer.sv
// ============================================================================
// Module   : pcm_rom_streamer
// Purpose  : Streams mono PCM samples from a 1-cycle-latency ROM as attenuated
//            left/right word pairs over valid/ready. Define
//            PCM_ROM_STREAMER_LOOP_EN to replay the clip endlessly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_rom_streamer
  import audio_pkg::*;
#(
  parameter int W  = 16,
  parameter int L  = 50000,
  parameter int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    volume,
  output logic [AW-1:0] rom_addr,
  input  logic [W-1:0]  rom_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_data,
  output logic          o_ws,
  output logic          busy,
  output logic          done,
  output logic          shutdown
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

  streamer_state_t state_q, state_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [W-1:0]    hold_q, hold_d;
  logic            last_q, last_d;
  logic [W-1:0]    atten_sample;
  logic            start_ok;
  logic            xfer_r;

  pcm_attenuator #(
    .W  (W),
    .SW (3)
  ) u_atten (
    .i_sample (rom_data),
    .i_shift  (volume),
    .o_sample (atten_sample)
  );

  // start is only honoured from the two resting states.
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_STOP));
  assign xfer_r   = (state_q == S_SEND_R) && i_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_SEND_L;
      S_SEND_L: if (i_ready) state_d = S_SEND_R;
      S_SEND_R: begin
        if (i_ready) begin
`ifdef PCM_ROM_STREAMER_LOOP_EN
          state_d = S_FETCH;
`else
          state_d = last_q ? S_DONE : S_FETCH;
`endif
        end
      end
      S_DONE:   state_d = S_STOP;
      S_STOP:   if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: address counter, sample hold and end-of-clip flag
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_addr_d = rom_addr_q;
    hold_d     = hold_q;
    last_d     = last_q;
    if (start_ok) begin
      rom_addr_d = '0;
    end else if (state_q == S_LATCH) begin
      hold_d = atten_sample;
      // The end test uses this flag, so the address may wrap freely.
      last_d     = (rom_addr_q == LAST_ADDR);
      rom_addr_d = (rom_addr_q == LAST_ADDR) ? '0 : rom_addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr_q <= '0;
      hold_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
    end
  end

`ifdef PCM_ROM_STREAMER_LOOP_EN
  logic done_q, done_d;

  // Looping never visits S_DONE, so the per-wrap pulse is registered here.
  always_comb begin
    done_d = xfer_r && last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid  = 1'b0;
    o_ws     = WS_LEFT;
    busy     = 1'b0;
    shutdown = 1'b1;
    case (state_q)
      S_FETCH, S_LATCH: busy = 1'b1;
      S_SEND_L: begin
        busy    = 1'b1;
        o_valid = 1'b1;
      end
      S_SEND_R: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        o_ws    = WS_RIGHT;
      end
      S_STOP:  shutdown = 1'b0;
      default: ;
    endcase
  end

`ifdef PCM_ROM_STREAMER_LOOP_EN
  assign done = done_q;
`else
  assign done = (state_q == S_DONE);
`endif

  assign o_data   = hold_q;
  assign rom_addr = rom_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_pcm_rom_streamer.sv
// ============================================================================
// Module   : tb_pcm_rom_streamer
// Purpose  : Directed self-checking bench for pcm_rom_streamer (L=4), with a
//            behavioural 1-cycle-latency ROM. Honours PCM_ROM_STREAMER_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcm_rom_streamer;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int AW = $clog2(L);

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          start   = 1'b0;
  logic [2:0]    volume  = 3'd0;
  logic          i_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          o_ws;
  logic          busy;
  logic          done;
  logic          shutdown;

  logic [W-1:0]  rom [0:L-1];

  int checks   = 0;
  int failures = 0;

  pcm_rom_streamer #(
    .W  (W),
    .L  (L),
    .AW (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .volume   (volume),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_ws     (o_ws),
    .busy     (busy),
    .done     (done),
    .shutdown (shutdown)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_rom(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
    rom[3] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
    checks++; if (o_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h want=0000", o_data); end
    checks++; if (o_ws !== 1'b1) begin failures++; $display("FAIL reset_ws got=%b want=1", o_ws); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (shutdown !== 1'b1) begin failures++; $display("FAIL reset_shutdown got=%b want=1", shutdown); end
    rst = 1'b1;
  endtask

  task automatic test_start();
    load_rom(16'h1234, 16'h0001, 16'h0002, 16'h0003);
    volume  = 3'd0;
    i_ready = 1'b1;
    do_reset();
    pulse_start();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL start_c1_valid got=%b want=0", o_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b want=1", busy); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL start_c2_valid got=%b want=0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL start_c3_valid got=%b want=1", o_valid); end
    checks++; if (o_data !== 16'h1234 || o_ws !== 1'b1) begin failures++; $display("FAIL start_left got=%h/%b want=1234/1", o_data, o_ws); end
    checks++; if (rom_addr !== AW'(1)) begin failures++; $display("FAIL start_addr got=%0d want=1", rom_addr); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h1234 || o_ws !== 1'b0) begin failures++; $display("FAIL start_right got=%b/%h/%b want=1/1234/0", o_valid, o_data, o_ws); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL start_fetch_valid got=%b want=0", o_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    load_rom(16'hABCD, 16'h0001, 16'h0002, 16'h0003);
    volume  = 3'd0;
    i_ready = 1'b0;
    do_reset();
    pulse_start();
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_valid want=valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 16'hABCD || o_ws !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/abcd/1", i, o_valid, o_data, o_ws);
      end
      tick();
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_data !== 16'hABCD || o_ws !== 1'b0) begin failures++; $display("FAIL bp_one_xfer got=%b/%h/%b want=1/abcd/0", o_valid, o_data, o_ws); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_ws !== 1'b0) begin failures++; $display("FAIL bp_right_hold got=%b/%b want=1/0", o_valid, o_ws); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_after got=%b want=0", o_valid); end
  endtask

  task automatic test_attenuation();
    bit ok;
    load_rom(16'h8000, 16'h0001, 16'h0002, 16'h0003);
    volume  = 3'd3;
    i_ready = 1'b1;
    do_reset();
    pulse_start();
    wait_valid(ok);
    volume = 3'd0;  // sample already latched, change must not matter
    checks++; if (!ok || o_data !== 16'hF000 || o_ws !== 1'b1) begin failures++; $display("FAIL att_neg_left got=%h/%b want=f000/1", o_data, o_ws); end
    tick();
    checks++; if (o_data !== 16'hF000 || o_ws !== 1'b0) begin failures++; $display("FAIL att_neg_right got=%h/%b want=f000/0", o_data, o_ws); end

    rom[0] = 16'h7FFF;
    volume = 3'd7;
    do_reset();
    pulse_start();
    wait_valid(ok);
    checks++; if (!ok || o_data !== 16'h00FF || o_ws !== 1'b1) begin failures++; $display("FAIL att_pos_left got=%h/%b want=00ff/1", o_data, o_ws); end
    tick();
    checks++; if (o_data !== 16'h00FF || o_ws !== 1'b0) begin failures++; $display("FAIL att_pos_right got=%h/%b want=00ff/0", o_data, o_ws); end
    volume = 3'd0;
  endtask

`ifndef PCM_ROM_STREAMER_LOOP_EN
  task automatic test_end_of_clip();
    bit ok;
    int nxf       = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int last_xcyc = -1;
    int word_err  = 0;
    logic [W-1:0] exp_d;
    load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    volume  = 3'd0;
    i_ready = 1'b1;
    do_reset();
    pulse_start();
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (o_valid && i_ready) begin
        if (nxf < 8) begin
          exp_d = rom[nxf / 2];
          if (o_data !== exp_d || o_ws !== ((nxf % 2) == 0)) word_err++;
        end
        nxf++;
        last_xcyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      tick();
    end
    checks++; if (word_err != 0) begin failures++; $display("FAIL eoc_words got=%0d_bad want=0_bad", word_err); end
    checks++; if (nxf != 8) begin failures++; $display("FAIL eoc_xfers got=%0d want=8", nxf); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL eoc_done_cycles got=%0d want=1", done_cnt); end
    checks++; if (done_cyc != last_xcyc + 1) begin failures++; $display("FAIL eoc_done_time got=%0d want=%0d", done_cyc, last_xcyc + 1); end
    checks++; if (busy !== 1'b0 || shutdown !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL eoc_stop got=busy%b/sd%b/v%b want=0/0/0", busy, shutdown, o_valid); end
    pulse_start();
    checks++; if (shutdown !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL eoc_rearm got=sd%b/busy%b want=1/1", shutdown, busy); end
    wait_valid(ok);
    checks++; if (!ok || o_data !== 16'h1111 || o_ws !== 1'b1) begin failures++; $display("FAIL eoc_replay got=%h/%b want=1111/1", o_data, o_ws); end
  endtask
`else
  task automatic test_loop();
    int nxf      = 0;
    int done_cnt = 0;
    int done_bad = 0;
    int word_err = 0;
    int sd_bad   = 0;
    logic [W-1:0] exp_d;
    load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    volume  = 3'd0;
    i_ready = 1'b1;
    do_reset();
    pulse_start();
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (o_valid && i_ready) begin
        exp_d = rom[(nxf / 2) % L];
        if (o_data !== exp_d || o_ws !== ((nxf % 2) == 0)) word_err++;
        nxf++;
      end
      if (done) begin
        done_cnt++;
        if ((nxf % 8) != 0 || nxf == 0) done_bad++;
      end
      if (shutdown !== 1'b1 || busy !== 1'b1) sd_bad++;
      tick();
    end
    checks++; if (word_err != 0) begin failures++; $display("FAIL loop_words got=%0d_bad want=0_bad", word_err); end
    checks++; if (nxf < 17) begin failures++; $display("FAIL loop_xfers got=%0d want>=17", nxf); end
    checks++; if (done_cnt < 2 || done_cnt != nxf / 8) begin failures++; $display("FAIL loop_done_cnt got=%0d want=%0d", done_cnt, nxf / 8); end
    checks++; if (done_bad != 0) begin failures++; $display("FAIL loop_done_pos got=%0d_bad want=0_bad", done_bad); end
    checks++; if (sd_bad != 0) begin failures++; $display("FAIL loop_shutdown_busy got=%0d_bad want=0_bad", sd_bad); end
  endtask
`endif

  task automatic test_reset_midstream();
    bit ok;
    int nr = 0;
    load_rom(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    volume  = 3'd0;
    i_ready = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (o_valid && o_ws == 1'b0) begin
        nr++;
        if (nr == 2) break;
      end
      tick();
    end
    checks++; if (nr != 2 || rom_addr !== AW'(2)) begin failures++; $display("FAIL mid_reach got=%0d/addr%0d want=2/addr2", nr, rom_addr); end
    rst = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || rom_addr !== '0 || shutdown !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=v%b/a%0d/sd%b/b%b want=0/0/1/0", o_valid, rom_addr, shutdown, busy);
    end
    rst = 1'b1;
    pulse_start();
    wait_valid(ok);
    checks++; if (!ok || o_data !== 16'h0A0A || o_ws !== 1'b1 || rom_addr !== AW'(1)) begin
      failures++; $display("FAIL mid_replay got=%h/%b/a%0d want=0a0a/1/a1", o_data, o_ws, rom_addr);
    end
  endtask

  initial begin
    load_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_start();
    test_backpressure();
    test_attenuation();
`ifndef PCM_ROM_STREAMER_LOOP_EN
    test_end_of_clip();
`else
    test_loop();
`endif
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcm_rom_streamer.md
Name: pcm_rom_streamer

Overview:
- Upstream stage of the I2S controller: reads mono 16-bit PCM samples from a 1-cycle-latency block ROM and emits a stereo word stream over valid/ready.
- Each ROM sample is sent as a left word then a right word, with volume attenuation applied.
- Raises `done` and deasserts `shutdown` at end of clip. Replaces the ad-hoc sequencing FSM in the top level.

Parameters:
- W, 16, sample width in bits (signed two's complement).
- L, 50000, number of samples in ROM; addresses 0..L-1.
- AW, $clog2(L), ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low; the block is held in reset while rst==0 at posedge clk.
- start  in  1  one-cycle pulse; begins playback from address 0 when idle.
- volume  in  3  attenuation: output = sample >>> volume (arithmetic shift). Sampled when a sample is latched.
- rom_addr  out  AW  ROM read address.
- rom_data  in  W  ROM read data, valid one cycle after rom_addr.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream (I2S controller) ready.
- o_data  out  W  output word.
- o_ws  out  1  channel tag for o_data: 1=left, 0=right.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last right word is accepted.
- shutdown  out  1  amplifier enable, active-low shutdown; 1 while idle or playing, 0 in S_STOP.

Behaviour:
- Reset (rst==0): state=S_IDLE, rom_addr=0, o_valid=0, o_data=0, o_ws=1, busy=0, done=0, shutdown=1.
- Handshake: a word transfers on a cycle where o_valid && i_ready. While o_valid && !i_ready, o_data and o_ws are held stable. o_valid never drops without a transfer.
- S_IDLE: on start, set rom_addr=0, busy=1, go to S_FETCH. start is ignored in all other states.
- S_FETCH: ROM is addressed this cycle; go to S_LATCH.
- S_LATCH: capture sample = $signed(rom_data) >>> volume into the hold register. Increment rom_addr. Go to S_SEND_L.
- S_SEND_L: o_valid=1, o_ws=1, o_data=hold. On transfer go to S_SEND_R.
- S_SEND_R: o_valid=1, o_ws=0, o_data=hold.
  - On transfer, if the sample just sent was address L-1, go to S_DONE.
  - Otherwise go to S_FETCH.
- S_DONE: pulse done=1 for one cycle, busy=0, go to S_STOP.
- S_STOP: shutdown=0, o_valid=0. On start, re-arm (shutdown=1) and behave as start in S_IDLE.
- Latency: start to first o_valid is 3 cycles. With i_ready held high, the steady-state period is 4 cycles per sample (2 words).
- Addressing: rom_addr never exceeds L-1. The end-of-clip test uses a separate last flag computed as (rom_addr == L-1) at latch time, not the wrapped address.
- volume≥W-1 yields 0 or -1 (sign fill); no saturation needed.
- Simultaneous events:
  - rst==0 dominates everything.
  - start together with a transfer in S_SEND_R is ignored.
  - Reset mid-operation drops the in-flight word without completing the handshake.

Optional Feature:
- Macro: PCM_ROM_STREAMER_LOOP_EN.
- Defined: after the right word of address L-1 is accepted, rom_addr wraps to 0 and the FSM returns to S_FETCH. done pulses once per wrap; busy and shutdown stay 1. The only way to stop is reset.
- Undefined: stop-at-end behaviour as above.

Decomposition:
- Shared package audio_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - the streamer state enum;
  - constant WS_LEFT=1'b1 / WS_RIGHT=1'b0, shared with the I2S controller.
- One natural sub-module: pcm_attenuator (combinational signed arithmetic shift, W and shift width parameterised). It is reused later for per-channel gain.

Test Plan:
- Reset and start: rst=0 for 2 cycles, then start with i_ready=1 and ROM[0]=16'h1234, volume=0. Expect o_valid at cycle 3; words (1234,ws=1), (1234,ws=0); rom_addr reaches 1.
- Backpressure: i_ready=0 for 5 cycles during S_SEND_L. o_data and o_ws stay constant and o_valid stays 1. Exactly one transfer occurs once i_ready=1.
- Attenuation: ROM[0]=16'h8000, volume=3. Expect o_data=16'hF000 on both words. With ROM[0]=16'h7FFF and volume=7, expect 16'h00FF.
- End of clip: L=4, i_ready=1. Expect exactly 8 transfers, then done high for exactly 1 cycle, busy=0, shutdown=0, no further o_valid.
- Loop build (PCM_ROM_STREAMER_LOOP_EN), L=4: the 9th word equals ROM[0] with ws=1. done pulses after words 8 and 16; shutdown stays 1.
- Reset mid-stream: assert rst=0 while o_valid=1 in S_SEND_R. Next cycle o_valid=0, rom_addr=0, shutdown=1. A new start replays from ROM[0].
